// File: rtl/rsa_core_arbiter.sv
// Shares one Rsa256Core between two requesters; one job in flight, round-robin on ties.
// Define RSA_ARB_FIXED_PRIO_EN to make requester 0 win every tie (last_grant is still tracked).
module rsa_core_arbiter #(
  parameter int unsigned W     = 256,
  parameter int unsigned CNT_W = 16
) (
  input  logic             avm_clk,
  input  logic             avm_rst,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [W-1:0]     req0_a_i,
  input  logic [W-1:0]     req0_d_i,
  input  logic [W-1:0]     req0_n_i,
  output logic             rsp0_valid_o,
  output logic [W-1:0]     rsp0_data_o,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [W-1:0]     req1_a_i,
  input  logic [W-1:0]     req1_d_i,
  input  logic [W-1:0]     req1_n_i,
  output logic             rsp1_valid_o,
  output logic [W-1:0]     rsp1_data_o,
  output logic             core_start_o,
  output logic [W-1:0]     core_a_o,
  output logic [W-1:0]     core_d_o,
  output logic [W-1:0]     core_n_o,
  input  logic [W-1:0]     core_result_i,
  input  logic             core_finished_i,
  output logic             busy_o,
  output logic             owner_o,
  output logic [CNT_W-1:0] done_cnt0_o,
  output logic [CNT_W-1:0] done_cnt1_o
);

  typedef enum logic [1:0] {StIdle, StStart, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [W-1:0]     core_a_q, core_a_d, core_d_q, core_d_d, core_n_q, core_n_d;
  logic [W-1:0]     rsp0_data_q, rsp0_data_d, rsp1_data_q, rsp1_data_d;
  logic             rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
  logic [CNT_W-1:0] done_cnt0_q, done_cnt0_d, done_cnt1_q, done_cnt1_d;
  logic             grant0, grant1;

  // last_grant_q == 1 means requester 1 was served last, so requester 0 wins a tie.
  always_comb begin
`ifdef RSA_ARB_FIXED_PRIO_EN
    grant0 = req0_valid_i;
    grant1 = req1_valid_i & ~req0_valid_i;
`else
    grant0 = req0_valid_i & (~req1_valid_i | last_grant_q);
    grant1 = req1_valid_i & (~req0_valid_i | ~last_grant_q);
`endif
  end

  assign req0_ready_o = (state_q == StIdle) & grant0;
  assign req1_ready_o = (state_q == StIdle) & grant1;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    core_a_d     = core_a_q;
    core_d_d     = core_d_q;
    core_n_d     = core_n_q;
    rsp0_data_d  = rsp0_data_q;
    rsp1_data_d  = rsp1_data_q;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    done_cnt0_d  = done_cnt0_q;
    done_cnt1_d  = done_cnt1_q;
    unique case (state_q)
      StIdle: begin
        if (grant0 | grant1) begin
          owner_d  = grant1;
          core_a_d = grant1 ? req1_a_i : req0_a_i;
          core_d_d = grant1 ? req1_d_i : req0_d_i;
          core_n_d = grant1 ? req1_n_i : req0_n_i;
          state_d  = StStart;
        end
      end
      StStart: state_d = StRun;
      StRun: begin
        if (core_finished_i) begin
          if (owner_q) rsp1_data_d = core_result_i;
          else         rsp0_data_d = core_result_i;
          state_d = StDone;
        end
      end
      StDone: begin
        if (owner_q) begin
          rsp1_valid_d = 1'b1;
          done_cnt1_d  = done_cnt1_q + 1'b1;
        end else begin
          rsp0_valid_d = 1'b1;
          done_cnt0_d  = done_cnt0_q + 1'b1;
        end
        last_grant_d = owner_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      core_a_q     <= '0;
      core_d_q     <= '0;
      core_n_q     <= '0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      done_cnt0_q  <= '0;
      done_cnt1_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      core_a_q     <= core_a_d;
      core_d_q     <= core_d_d;
      core_n_q     <= core_n_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      done_cnt0_q  <= done_cnt0_d;
      done_cnt1_q  <= done_cnt1_d;
    end
  end

  assign core_start_o = (state_q == StStart);
  assign core_a_o     = core_a_q;
  assign core_d_o     = core_d_q;
  assign core_n_o     = core_n_q;
  assign rsp0_valid_o = rsp0_valid_q;
  assign rsp1_valid_o = rsp1_valid_q;
  assign rsp0_data_o  = rsp0_data_q;
  assign rsp1_data_o  = rsp1_data_q;
  assign busy_o       = (state_q != StIdle);
  assign owner_o      = owner_q;
  assign done_cnt0_o  = done_cnt0_q;
  assign done_cnt1_o  = done_cnt1_q;

endmodule

// File: tb/tb_rsa_core_arbiter.sv
// Bench for rsa_core_arbiter: directed job table, corner sequences and a randomized run, all
// checked cycle by cycle against a timestamp-based model; includes a behavioural core.
module tb_rsa_core_arbiter;
  localparam int unsigned W     = 256;
  localparam int unsigned CNT_W = 4;

  typedef struct {
    int unsigned  a;
    int unsigned  d;
    int unsigned  n;
    logic [W-1:0] exp;
  } job_t;

  typedef struct {
    bit          rst_before;
    int unsigned req;
    int unsigned a;
    int unsigned d;
    int unsigned n;
    int unsigned exp;
    bit          drain_after;
  } vec_t;

  logic             avm_clk = 1'b0;
  logic             avm_rst = 1'b1;
  logic             req_valid [2];
  logic [W-1:0]     req_a [2];
  logic [W-1:0]     req_d [2];
  logic [W-1:0]     req_n [2];
  logic             rdy0, rdy1, rv0, rv1, core_start, core_finished, busy, owner;
  logic [W-1:0]     rd0, rd1, core_a, core_d, core_n, core_result;
  logic [CNT_W-1:0] cnt0, cnt1;

  rsa_core_arbiter #(.W(W), .CNT_W(CNT_W)) dut (
    .avm_clk        (avm_clk),
    .avm_rst        (avm_rst),
    .req0_valid_i   (req_valid[0]),
    .req0_ready_o   (rdy0),
    .req0_a_i       (req_a[0]),
    .req0_d_i       (req_d[0]),
    .req0_n_i       (req_n[0]),
    .rsp0_valid_o   (rv0),
    .rsp0_data_o    (rd0),
    .req1_valid_i   (req_valid[1]),
    .req1_ready_o   (rdy1),
    .req1_a_i       (req_a[1]),
    .req1_d_i       (req_d[1]),
    .req1_n_i       (req_n[1]),
    .rsp1_valid_o   (rv1),
    .rsp1_data_o    (rd1),
    .core_start_o   (core_start),
    .core_a_o       (core_a),
    .core_d_o       (core_d),
    .core_n_o       (core_n),
    .core_result_i  (core_result),
    .core_finished_i(core_finished),
    .busy_o         (busy),
    .owner_o        (owner),
    .done_cnt0_o    (cnt0),
    .done_cnt1_o    (cnt1)
  );

  always #5 avm_clk = ~avm_clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  job_t q0[$];
  job_t q1[$];
  int   order[$];

  // Model: one job at a time described by its accept and finish cycles.
  bit               m_active;
  int               m_acc, m_fin, m_pulse_cyc;
  logic             m_owner, m_pulse_owner, m_last;
  job_t             m_job;
  logic [W-1:0]     m_ops [3];
  logic [W-1:0]     m_rsp [2];
  logic [CNT_W-1:0] m_cnt [2];

  int drop_pct  = 0;
  int lat_force = 0;
  bit spur_en   = 0;
  bit glitch0   = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  function automatic logic [W-1:0] ref_pow(input int unsigned a, input int unsigned d,
                                           input int unsigned n);
    longint unsigned r;
    r = 64'(1 % n);
    for (int unsigned i = 0; i < d; i++) r = (r * 64'(a)) % 64'(n);
    return W'(r);
  endfunction

  // Behavioural core: square-and-multiply on whatever operands the arbiter presents.
  function automatic logic [W-1:0] core_pow(input logic [W-1:0] a, input logic [W-1:0] d,
                                            input logic [W-1:0] n);
    longint unsigned b, e, m, r;
    m = 64'(n[31:0]);
    e = 64'(d[31:0]);
    if (m == 0) return '0;
    b = 64'(a[31:0]) % m;
    r = 1 % m;
    while (e != 0) begin
      if (e[0]) r = (r * b) % m;
      b = (b * b) % m;
      e = e >> 1;
    end
    return W'(r);
  endfunction

  function automatic logic [W-1:0] rnd_w();
    return W'({8{$urandom()}});
  endfunction

  task automatic model_reset();
    m_active = 0; m_acc = -100; m_fin = -100; m_pulse_cyc = -100;
    m_owner = 0; m_pulse_owner = 0; m_last = 1;
    for (int i = 0; i < 3; i++) m_ops[i] = '0;
    for (int k = 0; k < 2; k++) begin m_rsp[k] = '0; m_cnt[k] = '0; end
    order.delete();
  endtask

  task automatic step();
    bit   v [2];
    bit   g [2];
    job_t j;
    int   lat;
    @(negedge avm_clk);
    v[0] = (q0.size() > 0) && ($urandom_range(99) >= drop_pct);
    v[1] = (q1.size() > 0) && ($urandom_range(99) >= drop_pct);
    for (int k = 0; k < 2; k++) begin
      if (v[k]) begin
        j = (k == 0) ? q0[0] : q1[0];
        req_a[k] = W'(j.a); req_d[k] = W'(j.d); req_n[k] = W'(j.n);
      end else begin
        req_a[k] = rnd_w(); req_d[k] = rnd_w(); req_n[k] = rnd_w();
      end
      req_valid[k] = v[k];
    end
    if (glitch0) begin
      v[0] = 1; req_valid[0] = 1; glitch0 = 0;
      req_a[0] = W'(3); req_d[0] = W'(4); req_n[0] = W'(7);
    end
    if (m_active && cyc == m_fin) begin
      core_finished = 1;
      core_result = core_pow(core_a, core_d, core_n);
    end else begin
      core_finished = spur_en && ($urandom_range(3) == 0) &&
                      (!m_active || cyc == m_acc + 1 || cyc == m_fin + 1);
      core_result = rnd_w();
    end
    #1;
    g[0] = 0; g[1] = 0;
    if (!m_active) begin
`ifdef RSA_ARB_FIXED_PRIO_EN
      g[0] = v[0];
      g[1] = v[1] && !v[0];
`else
      if (v[0] && v[1]) begin g[0] = m_last; g[1] = !m_last; end
      else begin g[0] = v[0]; g[1] = v[1]; end
`endif
    end
    chk("req0_ready", W'(rdy0), W'(g[0]));
    chk("req1_ready", W'(rdy1), W'(g[1]));
    chk("busy", W'(busy), W'(m_active));
    chk("core_start", W'(core_start), W'(m_active && cyc == m_acc + 1));
    chk("rsp0_valid", W'(rv0), W'(cyc == m_pulse_cyc && m_pulse_owner == 0));
    chk("rsp1_valid", W'(rv1), W'(cyc == m_pulse_cyc && m_pulse_owner == 1));
    chk("rsp0_data", rd0, m_rsp[0]);
    chk("rsp1_data", rd1, m_rsp[1]);
    chk("done_cnt0", W'(cnt0), W'(m_cnt[0]));
    chk("done_cnt1", W'(cnt1), W'(m_cnt[1]));
    chk("owner", W'(owner), W'(m_owner));
    chk("core_a", core_a, m_ops[0]);
    chk("core_d", core_d, m_ops[1]);
    chk("core_n", core_n, m_ops[2]);
    if (m_active && cyc == m_fin) m_rsp[m_owner] = m_job.exp;
    if (m_active && cyc == m_fin + 1) begin
      m_active = 0;
      m_pulse_cyc = cyc + 1;
      m_pulse_owner = m_owner;
      m_cnt[m_owner] = m_cnt[m_owner] + 1'b1;
      m_last = m_owner;
      order.push_back(int'(m_owner));
    end else if (g[0] || g[1]) begin
      m_job = g[1] ? q1.pop_front() : q0.pop_front();
      m_owner = g[1];
      m_ops[0] = W'(m_job.a); m_ops[1] = W'(m_job.d); m_ops[2] = W'(m_job.n);
      lat = (lat_force > 0) ? lat_force : $urandom_range(6, 1);
      m_active = 1; m_acc = cyc; m_fin = cyc + 1 + lat;
    end
    cyc++;
  endtask

  task automatic run_drain(input int max_cyc);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_active || cyc <= m_pulse_cyc) && n < max_cyc) begin
      step();
      n++;
    end
    chk("drain_timeout", W'(n >= max_cyc), W'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, W'(busy), W'(0));
    chk({tag, "_start"}, W'(core_start), W'(0));
    chk({tag, "_rv"}, W'({rv1, rv0}), W'(0));
    chk({tag, "_rd0"}, rd0, '0);
    chk({tag, "_rd1"}, rd1, '0);
    chk({tag, "_owner"}, W'(owner), W'(0));
    chk({tag, "_cnt"}, W'({cnt1, cnt0}), W'(0));
    chk({tag, "_core_ops"}, core_a | core_d | core_n, '0);
    chk({tag, "_ready"}, W'({rdy1, rdy0}), W'(0));
  endtask

  // Asserted mid-cycle: async reset must clear everything before the next edge.
  task automatic do_reset();
    req_valid[0] = 0; req_valid[1] = 0; core_finished = 0;
    #2;
    avm_rst = 1;
    #1;
    check_reset_outputs("rst");
    model_reset();
    @(negedge avm_clk);
    avm_rst = 0;
  endtask

  function automatic int order_code();
    int c;
    c = 0;
    for (int i = 0; i < order.size(); i++) c = c | (order[i] << i);
    return c;
  endfunction

  task automatic push_job(input int unsigned req, input int unsigned a, input int unsigned d,
                          input int unsigned n, input logic [W-1:0] e);
    job_t j;
    j.a = a; j.d = d; j.n = n; j.exp = e;
    if (req == 0) q0.push_back(j);
    else q1.push_back(j);
  endtask

  vec_t tbl [9];

  initial begin
    tbl[0] = '{0, 0, 3, 4, 7, 4, 1};
    tbl[1] = '{1, 0, 2, 10, 1000, 24, 0};
    tbl[2] = '{0, 1, 3, 4, 7, 4, 1};
    tbl[3] = '{0, 0, 2, 10, 1000, 24, 0};
    tbl[4] = '{0, 1, 3, 4, 7, 4, 0};
    tbl[5] = '{0, 0, 3, 4, 7, 4, 0};
    tbl[6] = '{0, 1, 2, 10, 1000, 24, 1};
    tbl[7] = '{1, 1, 5, 3, 13, 8, 0};
    tbl[8] = '{0, 1, 7, 2, 11, 5, 0};

    req_valid[0] = 0; req_valid[1] = 0; core_finished = 0; core_result = '0;
    for (int k = 0; k < 2; k++) begin req_a[k] = '0; req_d[k] = '0; req_n[k] = '0; end
    #2;
    check_reset_outputs("por");
    model_reset();
    @(negedge avm_clk);
    avm_rst = 0;

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].rst_before) do_reset();
      push_job(tbl[i].req, tbl[i].a, tbl[i].d, tbl[i].n, W'(tbl[i].exp));
      if (tbl[i].drain_after) run_drain(200);
      if (i == 0) begin
        chk("single_rsp0", rd0, W'(4));
        chk("single_cnt0", W'(cnt0), W'(1));
        chk("single_cnt1", W'(cnt1), W'(0));
      end
      if (i == 2) begin
        chk("pair_rsp0", rd0, W'(24));
        chk("pair_rsp1", rd1, W'(4));
        chk("pair_order", W'(order_code()), W'(2));
      end
      if (i == 6) begin
        chk("alt_len", W'(order.size()), W'(6));
`ifdef RSA_ARB_FIXED_PRIO_EN
        chk("alt_order", W'(order_code()), W'(50));
`else
        chk("alt_order", W'(order_code()), W'(42));
`endif
      end
    end
    push_job(1, 2, 8, 255, W'(1));
    run_drain(200);
    chk("b2b_rsp1", rd1, W'(1));
    chk("b2b_cnt1", W'(cnt1), W'(3));
    chk("b2b_cnt0", W'(cnt0), W'(0));

    // One-cycle req0 pulse while busy, then spurious core_finished while idle.
    push_job(1, 3, 4, 7, W'(4));
    lat_force = 5;
    step();
    step();
    glitch0 = 1;
    run_drain(200);
    lat_force = 0;
    chk("glitch_cnt0", W'(cnt0), W'(0));
    spur_en = 1;
    for (int i = 0; i < 12; i++) step();
    spur_en = 0;

    // Reset during RUN aborts the job; a fresh job afterwards completes normally.
    push_job(0, 2, 10, 1000, W'(24));
    lat_force = 6;
    for (int i = 0; i < 4; i++) step();
    chk("pre_reset_busy", W'(busy), W'(1));
    do_reset();
    lat_force = 0;
    for (int i = 0; i < 8; i++) step();
    push_job(0, 3, 4, 7, W'(4));
    run_drain(200);
    chk("post_reset_rsp0", rd0, W'(4));
    chk("post_reset_cnt0", W'(cnt0), W'(1));

    // Both valid continuously: 3 jobs for req0, 1 for req1.
    do_reset();
    for (int i = 0; i < 3; i++) push_job(0, 5, 3, 13, W'(8));
    push_job(1, 7, 2, 11, W'(5));
    run_drain(300);
`ifdef RSA_ARB_FIXED_PRIO_EN
    chk("prio_order", W'(order_code()), W'(8));
`else
    chk("prio_order", W'(order_code()), W'(2));
`endif

    // Randomized traffic with drops and spurious finishes; counters wrap at 2^CNT_W.
    do_reset();
    drop_pct = 30;
    spur_en = 1;
    for (int i = 0; i < 60; i++) begin
      int unsigned a, d, n, k;
      k = (i < 25) ? 0 : 1;
      if (i >= 50) k = $urandom_range(1);
      a = $urandom_range(1000);
      d = $urandom_range(50);
      n = $urandom_range(60000, 2);
      push_job(k, a, d, n, ref_pow(a, d, n));
    end
    run_drain(6000);
    drop_pct = 0;
    spur_en = 0;
    chk("rand_total", W'(order.size()), W'(60));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
